// File: rtl/ser_burst_gate.sv
// Burst-length serial gate: passes si to one of CH tri-state channel outputs for len bits.
// Define PAR_CHK_EN to append an even-parity bit to every burst.
module ser_burst_gate #(
   parameter int CNT_W = 8,
   parameter int CH    = 4,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic [SEL_W-1:0] ch_sel,
   input  logic             abort,
   input  logic             si,
   output wire  [CH-1:0]    so,
   output logic             busy,
   output logic             co,
   output logic             done
);

`ifdef PAR_CHK_EN
   typedef enum logic [1:0] {IDLE, PASS, PAR, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, PASS, DONE} state_t;
`endif

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [SEL_W-1:0] ch_q_reg;
   logic [CH-1:0]    so_q_reg;
   logic [CH-1:0]    oe_reg;
   logic [CH-1:0]    ch_hit;
   logic [CH-1:0]    so_si_next;
`ifdef PAR_CHK_EN
   logic             par_reg;
   logic [CH-1:0]    so_par_next;
`endif

   // A latched select at or above CH matches no channel, so nothing is ever driven.
   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         assign ch_hit[gi] = (ch_q_reg == SEL_W'(gi));
         assign so[gi]     = oe_reg[gi] ? so_q_reg[gi] : 1'bz;
      end
   endgenerate

   assign so_si_next  = (so_q_reg & ~ch_hit) | ({CH{si}} & ch_hit);
`ifdef PAR_CHK_EN
   assign so_par_next = (so_q_reg & ~ch_hit) | ({CH{par_reg}} & ch_hit);
`endif

   assign busy = (state_reg != IDLE);
   assign co   = (state_reg == PASS) && (&cnt_reg);
   assign done = (state_reg == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         ch_q_reg  <= '0;
         so_q_reg  <= '0;
         oe_reg    <= '0;
`ifdef PAR_CHK_EN
         par_reg   <= 1'b0;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  cnt_reg   <= ~len + CNT_W'(1);
                  ch_q_reg  <= ch_sel;
                  state_reg <= PASS;
`ifdef PAR_CHK_EN
                  par_reg   <= 1'b0;
`endif
               end
            end
            PASS: begin
               if (abort) begin
                  state_reg <= IDLE;
                  oe_reg    <= '0;
               end else begin
                  so_q_reg <= so_si_next;
                  oe_reg   <= oe_reg | ch_hit;
                  cnt_reg  <= cnt_reg + CNT_W'(1);
`ifdef PAR_CHK_EN
                  par_reg  <= par_reg ^ si;
                  if (&cnt_reg) state_reg <= PAR;
`else
                  if (&cnt_reg) state_reg <= DONE;
`endif
               end
            end
`ifdef PAR_CHK_EN
            PAR: begin
               // par_reg already includes the final bit captured on the last PASS edge.
               if (abort) begin
                  state_reg <= IDLE;
                  oe_reg    <= '0;
               end else begin
                  so_q_reg  <= so_par_next;
                  state_reg <= DONE;
               end
            end
`endif
            DONE: begin
               state_reg <= IDLE;
               oe_reg    <= '0;
            end
            default: begin
               state_reg <= IDLE;
               oe_reg    <= '0;
            end
         endcase
      end
   end

endmodule
